// File: rtl/ecc_err_event_logger_if.sv
// Event, configuration, read-port and status signals of the ECC error event logger.
// The master side drives events/config and consumes log entries; the slave side is the logger.
interface ecc_err_event_logger_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16
);
  localparam int ENTRY_W = TS_WIDTH + 18;
  localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;

  logic               enable;
  logic               evt_valid;
  logic               evt_corr;
  logic               evt_uncorr;
  logic [2:0]         evt_severity;
  logic [3:0]         evt_bit_count;
  logic [7:0]         evt_bit_pos;
  logic [7:0]         ce_thresh;
  logic [1:0]         irq_clr;
  logic               rd_valid;
  logic               rd_ready;
  logic [ENTRY_W-1:0] rd_data;
  logic [LVL_W-1:0]   fifo_level;
  logic [7:0]         drop_count;
  logic [7:0]         ce_count;
  logic               irq_ce;
  logic               irq_ue;

  modport master (
    output enable, evt_valid, evt_corr, evt_uncorr, evt_severity, evt_bit_count,
           evt_bit_pos, ce_thresh, irq_clr, rd_ready,
    input  rd_valid, rd_data, fifo_level, drop_count, ce_count, irq_ce, irq_ue
  );

  modport slave (
    input  enable, evt_valid, evt_corr, evt_uncorr, evt_severity, evt_bit_count,
           evt_bit_pos, ce_thresh, irq_clr, rd_ready,
    output rd_valid, rd_data, fifo_level, drop_count, ce_count, irq_ce, irq_ue
  );
endinterface

// File: rtl/ecc_err_event_logger.sv
// Time-stamps qualified ECC error events into a FIFO read via valid/ready; counts drops and CEs.
// Entries are visible one cycle after capture; a full FIFO drops unless it pops the same cycle.
module ecc_err_event_logger #(
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  ecc_err_event_logger_if.slave bus
);
  localparam int ENTRY_W = TS_WIDTH + 18;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;

  localparam logic [PTR_W-1:0]    PTR_ONE = 1;
  localparam logic [LVL_W-1:0]    LVL_ONE = 1;
  localparam logic [LVL_W-1:0]    LVL_MAX = LVL_W'(FIFO_DEPTH);
  localparam logic [TS_WIDTH-1:0] TS_ONE  = 1;

  logic [TS_WIDTH-1:0] r_ts;
  logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic                r_drop_flag;
  logic [7:0]          r_drop_cnt;
  logic [7:0]          r_ce_cnt;
  logic                r_irq_ce;
  logic                r_irq_ue;

  logic               w_qual;
  logic               w_ue;
  logic               w_ce;
  logic               w_corr_bit;
  logic               w_not_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [ENTRY_W-1:0] w_entry;
  logic [7:0]         w_ce_next;
  logic               w_ce_hit;

  // An event flagged both ways is logged as uncorrectable only.
  assign w_qual      = bus.evt_valid && bus.enable && (bus.evt_corr || bus.evt_uncorr);
  assign w_ue        = w_qual && bus.evt_uncorr;
  assign w_corr_bit  = bus.evt_corr && !bus.evt_uncorr;
  assign w_ce        = w_qual && w_corr_bit;

  assign w_not_empty = (r_level != '0);
  assign w_pop       = w_not_empty && bus.rd_ready;
  assign w_push      = w_qual && ((r_level != LVL_MAX) || w_pop);
  assign w_drop      = w_qual && !w_push;

  assign w_entry = {r_ts, r_drop_flag, bus.evt_uncorr, w_corr_bit,
                    bus.evt_severity, bus.evt_bit_count, bus.evt_bit_pos};

  // A clear coinciding with a CE restarts the count at 1 and re-evaluates the threshold.
  assign w_ce_next = bus.irq_clr[0] ? {7'd0, w_ce}
                   : (w_ce && (r_ce_cnt != 8'hFF)) ? r_ce_cnt + 8'd1
                   : r_ce_cnt;
  assign w_ce_hit  = w_ce && (bus.ce_thresh != 8'd0) && (w_ce_next >= bus.ce_thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts        <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_drop_flag <= 1'b0;
      r_drop_cnt  <= 8'd0;
      r_ce_cnt    <= 8'd0;
      r_irq_ce    <= 1'b0;
      r_irq_ue    <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_ONE;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_level <= r_level + LVL_ONE;
      else if (w_pop && !w_push) r_level <= r_level - LVL_ONE;
      if (w_drop) begin
        r_drop_flag <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end else if (w_push) begin
        r_drop_flag <= 1'b0;
      end
      r_ce_cnt <= w_ce_next;
      r_irq_ce <= w_ce_hit || (r_irq_ce && !bus.irq_clr[0]);
      r_irq_ue <= w_ue || (r_irq_ue && !bus.irq_clr[1]);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry;
  end

  assign bus.rd_valid   = w_not_empty;
  assign bus.rd_data    = w_not_empty ? r_mem[r_rd_ptr] : '0;
  assign bus.fifo_level = r_level;
  assign bus.drop_count = r_drop_cnt;
  assign bus.ce_count   = r_ce_cnt;
  assign bus.irq_ce     = r_irq_ce;
  assign bus.irq_ue     = r_irq_ue;
endmodule

// File: doc/ecc_err_event_logger.md
Name: ecc_err_event_logger

Overview:
- Consumes classified ECC error events from the error-type stage and time-stamps them.
- Buffers events in a FIFO that firmware or the register block reads through a valid/ready port.
- Counts dropped events.
- Raises sticky interrupts: immediately on any uncorrectable error, and on reaching a programmable correctable-error threshold.

Parameters:
FIFO_DEPTH, 16, log entries; power of 2, at least 2
TS_WIDTH, 16, free-running timestamp width
ENTRY_W, TS_WIDTH+18, derived width of rd_data; not overridable

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  logging enable; 0 ignores events (timestamp keeps running)
evt_valid  in  1  error event present this cycle
evt_corr  in  1  event is correctable
evt_uncorr  in  1  event is uncorrectable
evt_severity  in  3  severity code from classifier
evt_bit_count  in  4  error bit count
evt_bit_pos  in  8  error bit position (0xFF = multi-bit)
ce_thresh  in  8  correctable-event interrupt threshold; 0 disables
irq_clr  in  2  [0] clears irq_ce and CE counter; [1] clears irq_ue
rd_valid  out  1  FIFO head valid
rd_ready  in  1  consumer accepts head
rd_data  out  ENTRY_W  head entry
fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
drop_count  out  8  saturating count of dropped events
ce_count  out  8  correctable events since last irq_clr[0], saturating at 255
irq_ce  out  1  sticky CE-threshold interrupt
irq_ue  out  1  sticky UE interrupt

Behaviour:
- Reset values: all outputs 0, FIFO empty, timestamp 0, sticky drop flag 0.
- Timestamp: TS_WIDTH counter, +1 every cycle, wraps to 0.
- Qualified event:
  - evt_valid && enable && (evt_corr || evt_uncorr).
  - evt_valid with neither flag set is ignored.
  - Both flags set: treated as uncorrectable, with corr bit forced to 0 in the entry.
- Entry layout:
  - [ENTRY_W-1:18] timestamp at capture cycle
  - [17] drop_before
  - [16] uncorr
  - [15] corr
  - [14:12] severity
  - [11:8] bit_count
  - [7:0] bit_pos
- Push rule:
  - A qualified event pushes if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle (full + pop + push leaves the level at FIFO_DEPTH).
  - Otherwise the event is dropped: drop_count +1 (saturating at 255) and the sticky drop flag sets.
  - The next accepted entry carries drop_before = sticky flag, and the flag clears in that same cycle.
  - A drop and a clear in the same cycle are impossible (a push and a drop are mutually exclusive).
- Pop: rd_valid && rd_ready. rd_valid = (fifo_level != 0), registered state, no bypass.
  - A push into an empty FIFO makes rd_valid visible the next cycle.
  - rd_data always reflects the head; it is undefined-but-stable when empty (drive 0).
  - Simultaneous push and pop on a non-empty FIFO: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- CE counter: +1 per qualified correctable event, whether pushed or dropped; saturates at 255.
- irq_ce:
  - Sets the cycle after ce_count increments to a value >= ce_thresh, with ce_thresh != 0.
  - Sticky until irq_clr[0]; irq_clr[0] also zeroes ce_count.
  - Same-cycle CE event and irq_clr[0]: count becomes 1, and irq_ce evaluates against 1 (sets if ce_thresh == 1).
- irq_ue:
  - Sets the cycle after any qualified uncorrectable event, pushed or dropped.
  - Sticky until irq_clr[1]; set wins over a same-cycle clear.
- enable = 0: no pushes, drops or counter updates; pops continue; interrupts hold.
- Reset mid-operation: asynchronous clear of everything; entries are lost.

Test Plan:
- Single CE event (pos=5, sev=1, cnt=1) at timestamp 10 into empty FIFO, rd_ready=0 → next cycle rd_valid=1, rd_data={16'd10, 0, 0, 1, 3'd1, 4'd1, 8'd5}, fifo_level=1.
- 18 back-to-back CE events, FIFO_DEPTH=16, rd_ready=0 → fifo_level=16, drop_count=2. Then pop one and push one → the new entry has drop_before=1; drop_before is 0 on the entry after it.
- Push and pop in the same cycle on full FIFO → level stays 16, drop_count unchanged.
- ce_thresh=3, three CE events → irq_ce=1 the cycle after the third. Then irq_clr[0] → irq_ce=0, ce_count=0. Then ce_thresh=0 with 10 events → irq_ce stays 0.
- UE event (evt_corr=evt_uncorr=1) while FIFO full → irq_ue=1, drop_count +1. UE event and irq_clr[1] in the same cycle → irq_ue remains 1.
- Assert rst_n low with 5 entries queued → rd_valid, fifo_level, counters and irqs all 0 immediately; timestamp restarts at 0.
